// File: rtl/value_predictor_pkg.sv
// Shared definitions for the last-value load predictor and the core around it:
// default data/PC widths, table size and the D-cache request direction encoding.
package value_predictor_pkg;

  localparam int VP_DATA_WIDTH = 32;
  localparam int VP_ADDR_WIDTH = 32;
  localparam int VP_INDEX_BITS = 6;

  // Direction of a D-cache request, as carried on d_cache_req_write.
  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_action_e;

  // True when the request encoding denotes a read.
  function automatic logic is_read(input logic req_write);
    return mem_action_e'(req_write) == MEM_READ;
  endfunction

endpackage

// File: rtl/value_predictor_table.sv
// Last-value table: 2^INDEX_BITS entries of {valid, data}.
// Combinational lookup port (invalid entries read as zero) and one synchronous
// write port. Every entry is cleared by the asynchronous reset, so the store is
// built from flops rather than block RAM.
module value_predictor_table #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic                  entry_valid [ENTRIES];
  logic [DATA_WIDTH-1:0] entry_data  [ENTRIES];

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic                  valid_reg;
      logic [DATA_WIDTH-1:0] data_reg;
      logic                  hit_write;

      assign hit_write = wr_en && (wr_index == INDEX_BITS'(gi));

      // Entry storage: cleared on reset, overwritten when the write port selects it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else if (hit_write) begin
          valid_reg <= 1'b1;
          data_reg  <= wr_data;
        end
      end

      assign entry_valid[gi] = valid_reg;
      assign entry_data[gi]  = data_reg;
    end
  endgenerate

  // Lookup: an entry that has never been trained predicts zero.
  always_comb begin
    rd_data = '0;
    if (entry_valid[rd_index]) begin
      rd_data = entry_data[rd_index];
    end
  end

endmodule

// File: rtl/value_predictor.sv
// Last-value load predictor. On a D-cache read miss it forwards the value last
// seen for that load PC, then checks it against the real D-cache data. A match
// pulses done; a mismatch requests a register-snapshot restore and, once the
// restore is reported, pulses recovery_done_ack so fetch can restart from
// last_predicted_pc.
module value_predictor
  import value_predictor_pkg::*;
#(
  parameter int DATA_WIDTH = VP_DATA_WIDTH,
  parameter int ADDR_WIDTH = VP_ADDR_WIDTH,
  parameter int INDEX_BITS = VP_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vp_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  d_cache_req_valid,
  input  logic                  d_cache_req_write,
  input  logic                  d_cache_data_valid,
  input  logic [DATA_WIDTH-1:0] d_cache_data,
  input  logic                  out_lock_off,
  input  logic                  recovery_done,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  out_valid,
  output logic                  out_lock,
  output logic                  vp_lock,
  output logic                  done,
  output logic                  en_recover,
  output logic                  recovery_done_ack,
  output logic [ADDR_WIDTH-1:0] last_predicted_pc
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RECOVER = 2'd2,
    ACK     = 2'd3
  } state_e;

  state_e state_reg, state_next;

  logic [INDEX_BITS-1:0] index_reg, index_next;
  logic [DATA_WIDTH-1:0] out_reg, out_next;
  logic                  out_valid_reg, out_valid_next;
  logic                  out_lock_reg, out_lock_next;
  logic                  vp_lock_reg, vp_lock_next;
  logic                  done_reg, done_next;
  logic                  en_recover_reg, en_recover_next;
  logic                  ack_reg, ack_next;
  logic [ADDR_WIDTH-1:0] last_pc_reg, last_pc_next;

  logic [INDEX_BITS-1:0] lookup_index;
  logic [DATA_WIDTH-1:0] lookup_data;
  logic                  start;
  logic                  resolve;
  logic                  predict_hit;

  // Word-aligned PCs: drop the byte offset before indexing.
  assign lookup_index = addr[INDEX_BITS+1:2];

  // A prediction starts only for a read miss while nothing is outstanding.
  assign start   = (state_reg == IDLE) && vp_en && d_cache_req_valid
                   && is_read(d_cache_req_write);
  assign resolve = (state_reg == WAIT) && d_cache_data_valid;
  assign predict_hit = (d_cache_data == out_reg);

  value_predictor_table #(
    .DATA_WIDTH(DATA_WIDTH),
    .INDEX_BITS(INDEX_BITS)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (lookup_index),
    .rd_data  (lookup_data),
    .wr_en    (resolve),
    .wr_index (index_reg),
    .wr_data  (d_cache_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: one prediction in flight at a time, one ack per recovery.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (d_cache_data_valid) begin
          state_next = predict_hit ? IDLE : RECOVER;
        end
      end
      RECOVER: begin
        if (recovery_done) begin
          state_next = ACK;
        end
      end
      ACK: begin
        if (!recovery_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values for every registered output.
  always_comb begin
    index_next      = index_reg;
    out_next        = out_reg;
    out_valid_next  = out_valid_reg;
    vp_lock_next    = vp_lock_reg;
    last_pc_next    = last_pc_reg;
    done_next       = 1'b0;
    en_recover_next = 1'b0;
    ack_next        = 1'b0;

    // A new start takes priority over a same-cycle out_lock_off.
    if (start) begin
      out_lock_next = 1'b1;
    end else if (out_lock_off) begin
      out_lock_next = 1'b0;
    end else begin
      out_lock_next = out_lock_reg;
    end

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          index_next     = lookup_index;
          last_pc_next   = addr;
          out_next       = lookup_data;
          out_valid_next = 1'b1;
          vp_lock_next   = 1'b1;
        end
      end
      WAIT: begin
        if (d_cache_data_valid) begin
          out_valid_next  = 1'b0;
          vp_lock_next    = 1'b0;
          done_next       = predict_hit;
          en_recover_next = !predict_hit;
        end
      end
      RECOVER: begin
        en_recover_next = !recovery_done;
        ack_next        = recovery_done;
      end
      ACK: begin
        // Waiting for recovery_done to drop; no outputs asserted.
      end
      default: begin
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_reg      <= '0;
      out_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_lock_reg   <= 1'b0;
      vp_lock_reg    <= 1'b0;
      done_reg       <= 1'b0;
      en_recover_reg <= 1'b0;
      ack_reg        <= 1'b0;
      last_pc_reg    <= '0;
    end else begin
      index_reg      <= index_next;
      out_reg        <= out_next;
      out_valid_reg  <= out_valid_next;
      out_lock_reg   <= out_lock_next;
      vp_lock_reg    <= vp_lock_next;
      done_reg       <= done_next;
      en_recover_reg <= en_recover_next;
      ack_reg        <= ack_next;
      last_pc_reg    <= last_pc_next;
    end
  end

  assign out               = out_reg;
  assign out_valid         = out_valid_reg;
  assign out_lock          = out_lock_reg;
  assign vp_lock           = vp_lock_reg;
  assign done              = done_reg;
  assign en_recover        = en_recover_reg;
  assign recovery_done_ack = ack_reg;
  assign last_predicted_pc = last_pc_reg;

endmodule

// File: tb/tb_value_predictor.sv
// Directed bench for value_predictor: cold/warm predictions, mispredict with
// recovery handshake, ignored requests, out_lock priority and async reset.
module tb_value_predictor;

  logic        clk;
  logic        rst_n;
  logic        vp_en;
  logic [31:0] addr;
  logic        d_cache_req_valid;
  logic        d_cache_req_write;
  logic        d_cache_data_valid;
  logic [31:0] d_cache_data;
  logic        out_lock_off;
  logic        recovery_done;
  logic [31:0] out;
  logic        out_valid;
  logic        out_lock;
  logic        vp_lock;
  logic        done;
  logic        en_recover;
  logic        recovery_done_ack;
  logic [31:0] last_predicted_pc;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] PC_A = 32'h0040_0010;
  localparam logic [31:0] PC_B = 32'h0040_0020;
  localparam logic [31:0] PC_C = 32'h0040_0100;

  value_predictor dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .vp_en              (vp_en),
    .addr               (addr),
    .d_cache_req_valid  (d_cache_req_valid),
    .d_cache_req_write  (d_cache_req_write),
    .d_cache_data_valid (d_cache_data_valid),
    .d_cache_data       (d_cache_data),
    .out_lock_off       (out_lock_off),
    .recovery_done      (recovery_done),
    .out                (out),
    .out_valid          (out_valid),
    .out_lock           (out_lock),
    .vp_lock            (vp_lock),
    .done               (done),
    .en_recover         (en_recover),
    .recovery_done_ack  (recovery_done_ack),
    .last_predicted_pc  (last_predicted_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present a read-miss start for one cycle.
  task automatic start_predict(input logic [31:0] pc);
    vp_en = 1'b1; d_cache_req_valid = 1'b1; d_cache_req_write = 1'b0; addr = pc;
    tick();
    vp_en = 1'b0; d_cache_req_valid = 1'b0;
  endtask

  // Present D-cache response data for one cycle.
  task automatic return_data(input logic [31:0] data);
    d_cache_data_valid = 1'b1; d_cache_data = data;
    tick();
    d_cache_data_valid = 1'b0;
  endtask

  // Single-cycle recovery handshake after a mispredict.
  task automatic quick_recover();
    recovery_done = 1'b1;
    tick();
    recovery_done = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; vp_en = 1'b0; addr = '0; d_cache_req_valid = 1'b0;
    d_cache_req_write = 1'b0; d_cache_data_valid = 1'b0; d_cache_data = '0;
    out_lock_off = 1'b0; recovery_done = 1'b0;
    tick(); tick();
    check("reset_out", out, 32'h0);
    check("reset_flags", {26'b0, out_valid, out_lock, vp_lock, done, en_recover, recovery_done_ack}, 32'h0);
    check("reset_pc", last_predicted_pc, 32'h0);
    rst_n = 1'b1;
    tick();

    // Cold prediction: untrained entry predicts zero.
    start_predict(PC_A);
    $display("cold start pc=%h out=%h", PC_A, out);
    check("cold_out", out, 32'h0);
    check("cold_flags", {29'b0, out_valid, vp_lock, out_lock}, 32'h7);
    check("cold_pc", last_predicted_pc, PC_A);
    return_data(32'h0);
    $display("cold resolve data=0 done=%b", done);
    check("cold_done", {29'b0, done, en_recover, out_valid}, 32'h4);
    tick();
    check("cold_done_pulse", {31'b0, done}, 32'h0);

    // Train PC_A with 0xDEADBEEF (mispredict from 0).
    start_predict(PC_A);
    return_data(32'hDEAD_BEEF);
    $display("train pc=%h data=deadbeef en_recover=%b", PC_A, en_recover);
    check("train_recover", {31'b0, en_recover}, 32'h1);
    quick_recover();

    // Warm prediction with an ignored start while in WAIT.
    start_predict(PC_A);
    $display("warm start pc=%h out=%h", PC_A, out);
    check("warm_out", out, 32'hDEAD_BEEF);
    start_predict(PC_C);
    $display("ignored start pc=%h last_pc=%h", PC_C, last_predicted_pc);
    check("ignored_pc", last_predicted_pc, PC_A);
    check("ignored_out", out, 32'hDEAD_BEEF);
    return_data(32'hDEAD_BEEF);
    $display("warm resolve done=%b en_recover=%b", done, en_recover);
    check("warm_done", {30'b0, done, en_recover}, 32'h2);
    tick();
    check("warm_done_pulse", {30'b0, done, en_recover}, 32'h0);

    // Mispredict: train PC_B with 0x1234, then return 0x5678.
    start_predict(PC_B);
    return_data(32'h0000_1234);
    quick_recover();
    start_predict(PC_B);
    check("mis_out", out, 32'h0000_1234);
    return_data(32'h0000_5678);
    $display("mispredict pc=%h en_recover=%b", PC_B, en_recover);
    check("mis_recover", {30'b0, en_recover, done}, 32'h2);
    tick();
    check("mis_recover_hold", {30'b0, en_recover, recovery_done_ack}, 32'h2);
    recovery_done = 1'b1;
    tick();
    $display("recovery_done ack=%b pc=%h", recovery_done_ack, last_predicted_pc);
    check("ack_pulse", {30'b0, recovery_done_ack, en_recover}, 32'h2);
    check("ack_pc", last_predicted_pc, PC_B);
    tick();
    check("ack_once_1", {31'b0, recovery_done_ack}, 32'h0);
    tick();
    check("ack_once_2", {31'b0, recovery_done_ack}, 32'h0);
    recovery_done = 1'b0;
    tick();
    start_predict(PC_B);
    $display("retrained pc=%h out=%h", PC_B, out);
    check("table_updated", out, 32'h0000_5678);
    return_data(32'h0000_5678);
    check("retrained_done", {31'b0, done}, 32'h1);
    tick();

    // Write request with vp_en in IDLE must not predict.
    vp_en = 1'b1; d_cache_req_valid = 1'b1; d_cache_req_write = 1'b1; addr = PC_C;
    tick();
    vp_en = 1'b0; d_cache_req_valid = 1'b0; d_cache_req_write = 1'b0;
    $display("write request vp_lock=%b", vp_lock);
    check("write_no_predict", {30'b0, vp_lock, out_valid}, 32'h0);
    check("write_pc", last_predicted_pc, PC_B);

    // out_lock clear, then set-wins-over-clear.
    check("lock_before", {31'b0, out_lock}, 32'h1);
    out_lock_off = 1'b1;
    tick();
    check("lock_cleared", {31'b0, out_lock}, 32'h0);
    start_predict(PC_B);
    out_lock_off = 1'b0;
    $display("start with out_lock_off out_lock=%b", out_lock);
    check("lock_set_wins", {31'b0, out_lock}, 32'h1);
    return_data(32'h0000_5678);
    tick();

    // Asynchronous reset while in RECOVER.
    start_predict(PC_A);
    return_data(32'h0000_0001);
    check("pre_reset_recover", {31'b0, en_recover}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset en_recover=%b out_lock=%b pc=%h", en_recover, out_lock, last_predicted_pc);
    check("async_flags", {26'b0, out_valid, out_lock, vp_lock, done, en_recover, recovery_done_ack}, 32'h0);
    check("async_pc", last_predicted_pc, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    start_predict(PC_A);
    $display("post-reset pc=%h out=%h", PC_A, out);
    check("table_cleared_a", out, 32'h0);
    return_data(32'h0);
    tick();
    start_predict(PC_B);
    check("table_cleared_b", out, 32'h0);
    return_data(32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
